// File: rtl/alu_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// alu_ctrl_sequencer
//
// Moore fetch/decode/execute sequencer for register-register ALU
// instructions. It drives the datapath strobes cycle by cycle and returns
// one-hot register enables decoded from the instruction register.
//
// Optional feature macro: MEM_WAIT_EN
//   defined   : adds the mem_ready input; T1 holds until memory answers.
//   undefined : no mem_ready port; T1 always lasts one cycle.
//
// Parameters
//   NUM_REGS  general register count, width of reg_out/reg_in (<= 16)
//   OPC_W     opcode width, taken from ir[31 -: OPC_W]; also alu_op width
//
// Ports
//   clock      in   rising-edge clock
//   clear      in   asynchronous active-low reset
//   run        in   keep fetching/executing while high (sampled in IDLE/T5)
//   ir         in   instruction register: op, Ra[26:23], Rb[22:19], Rc[18:15]
//   mem_ready  in   memory read complete (MEM_WAIT_EN only)
//   PCout .. Zlowout  out  datapath strobes
//   reg_out    out  one-hot register-to-bus enable
//   reg_in     out  one-hot bus-to-register load
//   alu_op     out  opcode while Zin is high in execute, else 0
//   busy       out  high outside IDLE
//   done       out  one-cycle pulse in T5
//   illegal    out  one-cycle pulse in T3 when the instruction is rejected
// ---------------------------------------------------------------------------
module alu_ctrl_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic [31:0]         ir,
`ifdef MEM_WAIT_EN
  input  logic                mem_ready,
`endif
  output logic                PCout,
  output logic                IncPC,
  output logic                MARin,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [OPC_W-1:0]    alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5
  } state_t;

  state_t state_q, state_d;

  localparam logic [4:0] NREGS = 5'(NUM_REGS);

  logic [OPC_W-1:0] op;
  logic [3:0]       ra, rb, rc;
  logic             is_bin, is_un, ra_ok, rb_ok, rc_ok, legal, t1_exit;
  logic             unused_ir;

  assign op        = ir[31 -: OPC_W];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

  assign is_bin = (op >= OPC_W'(3)) && (op <= OPC_W'(10));
  assign is_un  = (op == OPC_W'(14)) || (op == OPC_W'(15));
  assign ra_ok  = {1'b0, ra} < NREGS;
  assign rb_ok  = {1'b0, rb} < NREGS;
  assign rc_ok  = {1'b0, rc} < NREGS;
  // Unary ops never read Rc, so its field is not range-checked for them.
  assign legal  = (is_bin && ra_ok && rb_ok && rc_ok) ||
                  (is_un && ra_ok && rb_ok);

`ifdef MEM_WAIT_EN
  assign t1_exit = mem_ready;
`else
  assign t1_exit = 1'b1;
`endif

  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
    onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (run) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    if (t1_exit) state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3: begin
        if (!legal)      state_d = S_IDLE;
        else if (is_bin) state_d = S_T4;
        else             state_d = S_T5;
      end
      S_T4:    state_d = S_T5;
      S_T5:    state_d = run ? S_T0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Outputs decode from the state register (and ir in T3..T5), so an
  // asynchronous clear forces every output low in the same cycle.
  always_comb begin
    PCout   = 1'b0;
    IncPC   = 1'b0;
    MARin   = 1'b0;
    PCin    = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    reg_out = '0;
    reg_in  = '0;
    alu_op  = '0;
    done    = 1'b0;
    illegal = 1'b0;
    case (state_q)
      S_T0: begin
        PCout = 1'b1;
        IncPC = 1'b1;
        MARin = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        // Read/MDRin stay up through any wait; the PC update only fires
        // in the cycle the sequencer actually leaves T1.
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = t1_exit;
        Zlowout = t1_exit;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (!legal) begin
          illegal = 1'b1;
        end else begin
          reg_out = onehot(rb);
          if (is_bin) begin
            Yin = 1'b1;
          end else begin
            Zin    = 1'b1;
            alu_op = op;
          end
        end
      end
      S_T4: begin
        reg_out = onehot(rc);
        Zin     = 1'b1;
        alu_op  = op;
      end
      S_T5: begin
        Zlowout = 1'b1;
        reg_in  = onehot(ra);
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_sequencer
//
// Directed bench for alu_ctrl_sequencer. A 16-register instance carries the
// main sequences; an 8-register instance sharing the same inputs covers the
// register-range rejection. Compile with +define+MEM_WAIT_EN to add the
// memory-wait sequence.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_sequencer;

  logic        clock;
  logic        clear;
  logic        run;
  logic [31:0] ir;
`ifdef MEM_WAIT_EN
  logic        mem_ready;
`endif

  logic        PCout, IncPC, MARin, PCin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
  logic [15:0] reg_out, reg_in;
  logic [4:0]  alu_op;
  logic        busy, done, illegal;

  logic        PCout8, IncPC8, MARin8, PCin8, Read8, MDRin8, MDRout8, IRin8, Yin8, Zin8, Zlowout8;
  logic [7:0]  reg_out8, reg_in8;
  logic [4:0]  alu_op8;
  logic        busy8, done8, illegal8;

  int errors = 0;
  int checks = 0;

  // Strobe vector order: PCout IncPC MARin PCin Read MDRin MDRout IRin Yin Zin Zlowout
  localparam logic [10:0] ST_NONE = 11'h000;
  localparam logic [10:0] ST_T0   = 11'h702;  // PCout IncPC MARin Zin
  localparam logic [10:0] ST_T1   = 11'h0E1;  // PCin Read MDRin Zlowout
  localparam logic [10:0] ST_WAIT = 11'h060;  // Read MDRin
  localparam logic [10:0] ST_T2   = 11'h018;  // MDRout IRin
  localparam logic [10:0] ST_YIN  = 11'h004;
  localparam logic [10:0] ST_ZIN  = 11'h002;
  localparam logic [10:0] ST_ZLO  = 11'h001;

  alu_ctrl_sequencer #(.NUM_REGS(16), .OPC_W(5)) dut16 (
    .clock(clock), .clear(clear), .run(run), .ir(ir),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .reg_out(reg_out), .reg_in(reg_in), .alu_op(alu_op),
    .busy(busy), .done(done), .illegal(illegal)
  );

  alu_ctrl_sequencer #(.NUM_REGS(8), .OPC_W(5)) dut8 (
    .clock(clock), .clear(clear), .run(run), .ir(ir),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .PCout(PCout8), .IncPC(IncPC8), .MARin(MARin8), .PCin(PCin8), .Read(Read8),
    .MDRin(MDRin8), .MDRout(MDRout8), .IRin(IRin8), .Yin(Yin8), .Zin(Zin8),
    .Zlowout(Zlowout8), .reg_out(reg_out8), .reg_in(reg_in8), .alu_op(alu_op8),
    .busy(busy8), .done(done8), .illegal(illegal8)
  );

  logic [50:0] obs16, obs8;
  assign obs16 = {PCout, IncPC, MARin, PCin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
                  reg_out, reg_in, alu_op, busy, done, illegal};
  assign obs8  = {PCout8, IncPC8, MARin8, PCin8, Read8, MDRin8, MDRout8, IRin8, Yin8, Zin8,
                  Zlowout8, 8'h00, reg_out8, 8'h00, reg_in8, alu_op8, busy8, done8, illegal8};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic chk16(input string tag, input logic [10:0] strb, input logic [15:0] rout,
                       input logic [15:0] rin, input logic [4:0] alu,
                       input logic b, input logic d, input logic il);
    logic [50:0] exp_v;
    exp_v = {strb, rout, rin, alu, b, d, il};
    checks++;
    assert (obs16 === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs16, exp_v);
    end
  endtask

  task automatic chk8(input string tag, input logic [10:0] strb, input logic [7:0] rout,
                      input logic [7:0] rin, input logic [4:0] alu,
                      input logic b, input logic d, input logic il);
    logic [50:0] exp_v;
    exp_v = {strb, 8'h00, rout, 8'h00, rin, alu, b, d, il};
    checks++;
    assert (obs8 === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs8, exp_v);
    end
  endtask

  initial begin
    clear = 1'b0;
    run   = 1'b0;
    ir    = 32'h0;
`ifdef MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    repeat (2) @(posedge clock);
    #2;
    chk16("reset", ST_NONE, 16'h0, 16'h0, 5'h0, 0, 0, 0);
    chk8("reset8", ST_NONE, 8'h0, 8'h0, 5'h0, 0, 0, 0);
    clear = 1'b1;
    cyc(); chk16("idle_run0", ST_NONE, 16'h0, 16'h0, 5'h0, 0, 0, 0);

    // Asynchronous clear in the middle of T4 of AND R1,R6,R7
    ir = 32'h28B38000; run = 1'b1;
    cyc(); chk16("rst_T0", ST_T0, 16'h0, 16'h0, 5'h0, 1, 0, 0);
    run = 1'b0;
    cyc(); cyc(); cyc();
    chk16("rst_T3", ST_YIN, 16'h0040, 16'h0, 5'h0, 1, 0, 0);
    cyc(); chk16("rst_T4", ST_ZIN, 16'h0080, 16'h0, 5'h05, 1, 0, 0);
    #1 clear = 1'b0;
    #1 chk16("rst_async", ST_NONE, 16'h0, 16'h0, 5'h0, 0, 0, 0);
    chk8("rst_async8", ST_NONE, 8'h0, 8'h0, 5'h0, 0, 0, 0);
    #2 clear = 1'b1;
    cyc(); chk16("rst_release_idle", ST_NONE, 16'h0, 16'h0, 5'h0, 0, 0, 0);

    // AND R1,R6,R7: six cycles T0..T5, run dropped after T0
    run = 1'b1;
    cyc(); chk16("and_T0", ST_T0, 16'h0, 16'h0, 5'h0, 1, 0, 0);
    run = 1'b0;
    cyc(); chk16("and_T1", ST_T1, 16'h0, 16'h0, 5'h0, 1, 0, 0);
    cyc(); chk16("and_T2", ST_T2, 16'h0, 16'h0, 5'h0, 1, 0, 0);
    cyc(); chk16("and_T3", ST_YIN, 16'h0040, 16'h0, 5'h0, 1, 0, 0);
    cyc(); chk16("and_T4", ST_ZIN, 16'h0080, 16'h0, 5'h05, 1, 0, 0);
    cyc(); chk16("and_T5", ST_ZLO, 16'h0, 16'h0002, 5'h0, 1, 1, 0);
    cyc(); chk16("and_idle", ST_NONE, 16'h0, 16'h0, 5'h0, 0, 0, 0);

    // NEG R4,R2: T4 skipped, done in the fifth cycle
    ir = 32'h72100000; run = 1'b1;
    cyc(); chk16("neg_T0", ST_T0, 16'h0, 16'h0, 5'h0, 1, 0, 0);
    run = 1'b0;
    cyc(); chk16("neg_T1", ST_T1, 16'h0, 16'h0, 5'h0, 1, 0, 0);
    cyc(); chk16("neg_T2", ST_T2, 16'h0, 16'h0, 5'h0, 1, 0, 0);
    cyc(); chk16("neg_T3", ST_ZIN, 16'h0004, 16'h0, 5'h0E, 1, 0, 0);
    cyc(); chk16("neg_T5", ST_ZLO, 16'h0, 16'h0010, 5'h0, 1, 1, 0);
    cyc(); chk16("neg_idle", ST_NONE, 16'h0, 16'h0, 5'h0, 0, 0, 0);

    // Illegal opcode 0x1F with run held high: back to IDLE anyway
    ir = 32'hF8000000; run = 1'b1;
    cyc(); chk16("ill_T0", ST_T0, 16'h0, 16'h0, 5'h0, 1, 0, 0);
    cyc(); cyc();
    chk16("ill_T2", ST_T2, 16'h0, 16'h0, 5'h0, 1, 0, 0);
    cyc(); chk16("ill_T3", ST_NONE, 16'h0, 16'h0, 5'h0, 1, 0, 1);
    chk8("ill_T3_8", ST_NONE, 8'h0, 8'h0, 5'h0, 1, 0, 1);
    cyc(); chk16("ill_idle", ST_NONE, 16'h0, 16'h0, 5'h0, 0, 0, 0);
    run = 1'b0;
    cyc(); chk16("ill_idle2", ST_NONE, 16'h0, 16'h0, 5'h0, 0, 0, 0);

    // ADD R1,R2,R9 (op 0x04): legal with 16 registers, Rc out of range with 8
    ir = 32'h20948000; run = 1'b1;
    cyc(); chk8("rc9_T0_8", ST_T0, 8'h0, 8'h0, 5'h0, 1, 0, 0);
    run = 1'b0;
    cyc(); cyc(); cyc();
    chk16("rc9_T3", ST_YIN, 16'h0004, 16'h0, 5'h0, 1, 0, 0);
    chk8("rc9_T3_8", ST_NONE, 8'h0, 8'h0, 5'h0, 1, 0, 1);
    cyc(); chk16("rc9_T4", ST_ZIN, 16'h0200, 16'h0, 5'h04, 1, 0, 0);
    chk8("rc9_idle_8", ST_NONE, 8'h0, 8'h0, 5'h0, 0, 0, 0);
    cyc(); chk16("rc9_T5", ST_ZLO, 16'h0, 16'h0002, 5'h0, 1, 1, 0);
    cyc(); chk16("rc9_idle", ST_NONE, 16'h0, 16'h0, 5'h0, 0, 0, 0);

    // Two back-to-back ADD R1,R2,R3 (op 0x03); run dropped in T2 of the second
    ir = 32'h18918000; run = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc(); chk16("add_T0", ST_T0, 16'h0, 16'h0, 5'h0, 1, 0, 0);
      cyc(); chk16("add_T1", ST_T1, 16'h0, 16'h0, 5'h0, 1, 0, 0);
      cyc(); chk16("add_T2", ST_T2, 16'h0, 16'h0, 5'h0, 1, 0, 0);
      if (k == 1) run = 1'b0;
      cyc(); chk16("add_T3", ST_YIN, 16'h0004, 16'h0, 5'h0, 1, 0, 0);
      cyc(); chk16("add_T4", ST_ZIN, 16'h0008, 16'h0, 5'h03, 1, 0, 0);
      cyc(); chk16("add_T5", ST_ZLO, 16'h0, 16'h0002, 5'h0, 1, 1, 0);
    end
    cyc(); chk16("add_idle", ST_NONE, 16'h0, 16'h0, 5'h0, 0, 0, 0);

`ifdef MEM_WAIT_EN
    // AND R1,R6,R7 with mem_ready low for three T1 cycles: done in cycle 9
    ir = 32'h28B38000; run = 1'b1; mem_ready = 1'b0;
    cyc(); chk16("mw_T0", ST_T0, 16'h0, 16'h0, 5'h0, 1, 0, 0);
    run = 1'b0;
    for (int w = 0; w < 3; w++) begin
      cyc(); chk16("mw_wait", ST_WAIT, 16'h0, 16'h0, 5'h0, 1, 0, 0);
    end
    cyc(); mem_ready = 1'b1;
    #1 chk16("mw_T1_exit", ST_T1, 16'h0, 16'h0, 5'h0, 1, 0, 0);
    cyc(); chk16("mw_T2", ST_T2, 16'h0, 16'h0, 5'h0, 1, 0, 0);
    cyc(); chk16("mw_T3", ST_YIN, 16'h0040, 16'h0, 5'h0, 1, 0, 0);
    cyc(); chk16("mw_T4", ST_ZIN, 16'h0080, 16'h0, 5'h05, 1, 0, 0);
    cyc(); chk16("mw_T5", ST_ZLO, 16'h0, 16'h0002, 5'h0, 1, 1, 0);
    cyc(); chk16("mw_idle", ST_NONE, 16'h0, 16'h0, 5'h0, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
